npu_act_wr_requester: RTL and testbench

// - Requester end of the 32-slot activation-memory write port. One instance per compute lane.
// - Takes raw accumulator results from a lane and requantises each to ACT_DW bits.
// - Buffers results in a small FIFO and drives one slot of hw_mem_wr/addr/data.
// - Holds each request until the memory controller returns that slot's hw_mem_wr_ack_p pulse.

---
 rtl/npu_act_wr_requester_if.sv | 45 ++++
 rtl/npu_act_wr_requester.sv | 167 ++++++++++++++++
 tb/tb_npu_act_wr_requester.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/npu_act_wr_requester_if.sv
// npu_act_wr_requester_if
// Groups the lane-side result handshake and the activation-memory write
// request port of one requester.
//   in_valid/in_ready/in_addr/in_acc   : accumulator results from the lane
//   hw_mem_wr/_addr/_data              : level write request, held until acked
//   hw_mem_wr_ack_p                    : one-cycle acknowledge from controller
// Modports:
//   master : the requester (npu_act_wr_requester)
//   slave  : the lane and controller side driving results and acks
interface npu_act_wr_requester_if #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ACT_DW = 16,
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [ACC_W-1:0]  in_acc;
    logic              hw_mem_wr;
    logic [ADDR_W-1:0] hw_mem_wr_addr;
    logic [ACT_DW-1:0] hw_mem_wr_data;
    logic              hw_mem_wr_ack_p;

    modport master (
        input  in_valid,
        input  in_addr,
        input  in_acc,
        input  hw_mem_wr_ack_p,
        output in_ready,
        output hw_mem_wr,
        output hw_mem_wr_addr,
        output hw_mem_wr_data
    );

    modport slave (
        output in_valid,
        output in_addr,
        output in_acc,
        output hw_mem_wr_ack_p,
        input  in_ready,
        input  hw_mem_wr,
        input  hw_mem_wr_addr,
        input  hw_mem_wr_data
    );
endinterface

// File: rtl/npu_act_wr_requester.sv
// npu_act_wr_requester
// Requester end of one slot of the activation-memory write port. Accumulator
// results are requantised (round-half-up, arithmetic right shift, saturate to
// ACT_DW bits) in a registered stage, buffered in a FIFO_DEPTH-entry FIFO and
// presented as a level write request that is held until the controller acks.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   bus          : npu_act_wr_requester_if.master (lane handshake + write port)
//   cfg_shift    : requant right-shift 0..31, static while busy
//   idle         : nothing in the stage register or FIFO
//   err_sticky   : [0] input dropped while not ready, [1] ack with no request
// Build option: define NPU_ACT_WR_RELU_EN to clamp negative results to zero.
`ifndef NPU_ACT_DATA_WIDTH
`define NPU_ACT_DATA_WIDTH 16
`endif
`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 10
`endif

module npu_act_wr_requester #(
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned ACT_DW     = `NPU_ACT_DATA_WIDTH,
    parameter int unsigned ADDR_W     = `LOG2_ACT_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    npu_act_wr_requester_if.master        bus,
    input  logic [4:0]                    cfg_shift,
    output logic                          idle,
    output logic [1:0]                    err_sticky
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW   = ACC_W + 1;
    localparam int unsigned HiW  = TW - ACT_DW + 1;

    localparam logic [ACT_DW-1:0] ActMax = {1'b0, {(ACT_DW-1){1'b1}}};
`ifndef NPU_ACT_WR_RELU_EN
    localparam logic [ACT_DW-1:0] ActMin = {1'b1, {(ACT_DW-1){1'b0}}};
`endif

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
    logic [ACT_DW-1:0] s1_data_q,  s1_data_d;

    // FIFO state
    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [FIFO_DEPTH];
    logic [ACT_DW-1:0] mem_data_q [FIFO_DEPTH];
    logic [ACT_DW-1:0] mem_data_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q,    cnt_d;
    logic [1:0]        err_q,    err_d;

    // Requantisation datapath
    logic [TW-1:0]        rnd_bias;
    logic signed [TW-1:0] round_t;
    logic signed [TW-1:0] shifted_t;
    logic [HiW-1:0]       hi_bits;
    logic                 fits;
    logic [ACT_DW-1:0]    req_data;

    logic [CntW:0] occupancy;
    logic          in_ready_c;
    logic          accept;
    logic          push;
    logic          pop;
    logic          wr_req;

    always_comb begin
        rnd_bias = '0;
        if (cfg_shift != 5'd0) begin
            rnd_bias = TW'(1) << (cfg_shift - 5'd1);
        end
        // One extra bit so adding the rounding bias can never wrap.
        round_t   = $signed({bus.in_acc[ACC_W-1], bus.in_acc}) + $signed(rnd_bias);
        shifted_t = round_t >>> cfg_shift;
        // Value fits in ACT_DW bits iff all bits from the ACT_DW sign position up agree.
        hi_bits   = shifted_t[TW-1:ACT_DW-1];
        fits      = (&hi_bits) | ~(|hi_bits);
`ifdef NPU_ACT_WR_RELU_EN
        if (shifted_t[TW-1]) begin
            req_data = '0;
        end else if (!fits) begin
            req_data = ActMax;
        end else begin
            req_data = shifted_t[ACT_DW-1:0];
        end
`else
        if (fits) begin
            req_data = shifted_t[ACT_DW-1:0];
        end else if (shifted_t[TW-1]) begin
            req_data = ActMin;
        end else begin
            req_data = ActMax;
        end
`endif
    end

    always_comb begin
        // Stage-1 occupancy is counted so a registered result always has a slot.
        occupancy  = {1'b0, cnt_q} + {{CntW{1'b0}}, s1_valid_q};
        in_ready_c = occupancy < (CntW + 1)'(FIFO_DEPTH);
        wr_req     = cnt_q != '0;
        accept     = bus.in_valid & in_ready_c;
        push       = s1_valid_q;
        pop        = bus.hw_mem_wr_ack_p & wr_req;

        s1_valid_d = accept;
        s1_addr_d  = accept ? bus.in_addr : s1_addr_q;
        s1_data_d  = accept ? req_data    : s1_data_q;

        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = s1_addr_q;
            mem_data_d[wr_ptr_q] = s1_data_q;
        end

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | {bus.hw_mem_wr_ack_p & ~wr_req, bus.in_valid & ~in_ready_c};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.hw_mem_wr      = wr_req;
    assign bus.hw_mem_wr_addr = mem_addr_q[rd_ptr_q];
    assign bus.hw_mem_wr_data = mem_data_q[rd_ptr_q];
    assign idle               = (cnt_q == '0) & ~s1_valid_q;
    assign err_sticky         = err_q;
endmodule

// File: tb/tb_npu_act_wr_requester.sv
module tb_npu_act_wr_requester;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned ACT_DW = 16;
    localparam int unsigned ADDR_W = 10;

    logic       clk;
    logic       resetn;
    logic [4:0] cfg_shift;
    logic       idle;
    logic [1:0] err_sticky;

    npu_act_wr_requester_if #(.ACC_W(ACC_W), .ACT_DW(ACT_DW), .ADDR_W(ADDR_W)) bus_if ();

    npu_act_wr_requester #(
        .ACC_W(ACC_W), .ACT_DW(ACT_DW), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus_if),
        .cfg_shift  (cfg_shift),
        .idle       (idle),
        .err_sticky (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one input for one cycle and queue its expected write.
    task automatic send(input logic [9:0] addr, input logic [31:0] acc, input logic [15:0] exp);
        bus_if.in_valid = 1'b1;
        bus_if.in_addr  = addr;
        bus_if.in_acc   = acc;
        check("send_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        sb.push_back({6'd0, addr, exp});
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, then ack it for one cycle.
    task automatic ack_once();
        int waited = 0;
        while (bus_if.hw_mem_wr !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        check("ack_req_present", {31'd0, bus_if.hw_mem_wr}, 32'd1);
        if (bus_if.hw_mem_wr === 1'b1) begin
            bus_if.hw_mem_wr_ack_p = 1'b1;
            tick();
            bus_if.hw_mem_wr_ack_p = 1'b0;
        end
    endtask

    // Monitor: every acked write is compared against the scoreboard head.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus_if.hw_mem_wr === 1'b1 && bus_if.hw_mem_wr_ack_p === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                         bus_if.hw_mem_wr_addr, bus_if.hw_mem_wr_data);
            end else begin
                check("wr_beat", {6'd0, bus_if.hw_mem_wr_addr, bus_if.hw_mem_wr_data},
                      sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [15:0] exp_min;
        logic [15:0] exp_neg;
`ifdef NPU_ACT_WR_RELU_EN
        exp_min = 16'h0000;
        exp_neg = 16'h0000;
`else
        exp_min = 16'h8000;
        exp_neg = 16'hFFE7;
`endif
        resetn                 = 1'b0;
        cfg_shift              = 5'd0;
        bus_if.in_valid        = 1'b0;
        bus_if.in_addr         = '0;
        bus_if.in_acc          = '0;
        bus_if.hw_mem_wr_ack_p = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_hw_mem_wr", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("rst_err", {30'd0, err_sticky}, 32'd0);
        check("rst_addr", {22'd0, bus_if.hw_mem_wr_addr}, 32'd0);
        check("rst_data", {16'd0, bus_if.hw_mem_wr_data}, 32'd0);
        resetn = 1'b1;
        tick();

        // Round-half-up: (1072 + 16) >>> 5 = 34
        cfg_shift = 5'd5;
        send(10'h010, 32'd1072, 16'h0022);
        check("rnd_wr_after1", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("rnd_idle_after1", {31'd0, idle}, 32'd0);
        tick();
        check("rnd_wr_after2", {31'd0, bus_if.hw_mem_wr}, 32'd1);
        check("rnd_addr", {22'd0, bus_if.hw_mem_wr_addr}, 32'h10);
        check("rnd_data", {16'd0, bus_if.hw_mem_wr_data}, 32'h22);
        bus_if.hw_mem_wr_ack_p = 1'b1;
        tick();
        bus_if.hw_mem_wr_ack_p = 1'b0;
        check("rnd_wr_cleared", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("rnd_idle_done", {31'd0, idle}, 32'd1);

        // Saturation at shift 0
        cfg_shift = 5'd0;
        send(10'h001, 32'h7FFF_FFFF, 16'h7FFF);
        send(10'h002, 32'h8000_0000, exp_min);
        ack_once();
        ack_once();

        // Negative rounding: (-100 + 2) >>> 2 = -25
        cfg_shift = 5'd2;
        send(10'h003, -32'sd100, exp_neg);
        ack_once();

        // Backpressure: six offers, no acks
        cfg_shift = 5'd0;
        for (int i = 0; i < 6; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_addr  = 10'h020 + 10'(i);
            bus_if.in_acc   = 32'(i * 7);
            if (i < 4) begin
                check("bp_ready_open", {31'd0, bus_if.in_ready}, 32'd1);
                sb.push_back({6'd0, 10'h020 + 10'(i), 16'(i * 7)});
            end else begin
                check("bp_ready_blocked", {31'd0, bus_if.in_ready}, 32'd0);
            end
            tick();
        end
        bus_if.in_valid = 1'b0;
        check("bp_err_drop", {31'd0, err_sticky[0]}, 32'd1);
        check("bp_err_ack", {31'd0, err_sticky[1]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (32) tick();
            check("bp_wr_held", {31'd0, bus_if.hw_mem_wr}, 32'd1);
            ack_once();
        end
        check("bp_idle_after", {31'd0, idle}, 32'd1);
        check("bp_wr_after", {31'd0, bus_if.hw_mem_wr}, 32'd0);

        // Simultaneous push and pop at count 2
        send(10'h030, 32'd48, 16'd48);
        send(10'h031, 32'd49, 16'd49);
        tick();
        bus_if.in_valid = 1'b1;
        bus_if.in_addr  = 10'h032;
        bus_if.in_acc   = 32'd50;
        check("pp_ready", {31'd0, bus_if.in_ready}, 32'd1);
        sb.push_back({6'd0, 10'h032, 16'd50});
        tick();
        bus_if.in_valid        = 1'b0;
        bus_if.hw_mem_wr_ack_p = 1'b1;
        tick();
        bus_if.hw_mem_wr_ack_p = 1'b0;
        check("pp_wr_still", {31'd0, bus_if.hw_mem_wr}, 32'd1);
        ack_once();
        check("pp_wr_one_left", {31'd0, bus_if.hw_mem_wr}, 32'd1);
        ack_once();
        check("pp_wr_drained", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("pp_idle", {31'd0, idle}, 32'd1);

        // Stray ack with nothing queued
        bus_if.hw_mem_wr_ack_p = 1'b1;
        tick();
        bus_if.hw_mem_wr_ack_p = 1'b0;
        check("stray_err", {30'd0, err_sticky}, 32'd3);
        check("stray_idle", {31'd0, idle}, 32'd1);
        check("stray_wr", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("stray_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // Reset with three entries queued
        send(10'h040, 32'd1, 16'd1);
        send(10'h041, 32'd2, 16'd2);
        send(10'h042, 32'd3, 16'd3);
        tick();
        check("mid_wr_before", {31'd0, bus_if.hw_mem_wr}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_wr", {31'd0, bus_if.hw_mem_wr}, 32'd0);
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        check("mid_rst_err", {30'd0, err_sticky}, 32'd0);
        sb.delete();
        tick();
        tick();
        resetn = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus_if.hw_mem_wr !== 1'b0) seen = 1;
        end
        check("mid_no_write", 32'(seen), 32'd0);
        send(10'h050, 32'd64, 16'h0040);
        ack_once();
        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
